bcd_result_formatter: RTL and testbench
=======================================

# bcd_result_formatter

Sequential binary-to-BCD stage that sits directly upstream of the seven-segment LED driver. It snapshots the two signed binary operands and the signed binary result on a `start` pulse. It converts each one in turn to sign-magnitude 10-bit BCD (hundreds digit 0–3, tens, ones) using one shared shift-and-add-3 core. It then presents all outputs and the result-overflow flag atomically, with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 12: width of the two's-complement binary inputs. Must be ≥ 10.
- `MAX_MAG`, 399: largest displayable magnitude. Must be ≤ 399 because the hundreds digit is 2 bits.

- `clk`  in  1  sole clock; everything is updated on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a conversion. Sampled only in IDLE.
- `a_bin`  in  WIDTH  operand A, signed two's complement.
- `b_bin`  in  WIDTH  operand B, signed two's complement.
- `d_bin`  in  WIDTH  arithmetic result, signed two's complement.
- `A`, `B`, `D`  out  10 each  BCD as {hundreds[1:0], tens[3:0], ones[3:0]}.
- `negativeA`, `negativeB`, `negativeD`  out  1 each  sign of the displayed value.
- `overflow`  out  1  |d_bin| > MAX_MAG.
- `busy`  out  1  conversion in progress.
- `done`  out  1  single-cycle pulse: new outputs are valid.

## Operation
- **Reset values:** all outputs are 0 (A=B=D=10'h000, all negatives 0, overflow 0, busy 0, done 0). The FSM returns to IDLE.
- **FSM states:** IDLE → LOAD → SHIFT → STORE → (LOAD for the next channel | COMMIT) → IDLE.
- **IDLE:**
  - If `start` is high, snapshot a_bin, b_bin and d_bin into internal registers.
  - Set channel index = 0 (A) and go to LOAD.
  - `start` is ignored in every other state.
- **LOAD (1 cycle):**
  - Sign = MSB of the snapshot. Magnitude = |x| as an unsigned WIDTH-bit value (-2^(WIDTH-1) → 2^(WIDTH-1)).
  - **A/B channels:** if magnitude > MAX_MAG, saturate to MAX_MAG; the sign is kept.
  - **D channel:** if magnitude > MAX_MAG, set the overflow staging bit, load magnitude 0 and force sign 0.
  - Clear the 12-bit BCD accumulator and the bit counter.
- **SHIFT (WIDTH cycles):**
  - Each cycle: add 3 to every BCD nibble that is ≥ 5, then shift {bcd, mag} left by 1.
  - The cycle count is always exactly WIDTH, independent of value, so latency is fixed.
- **STORE (1 cycle):**
  - Write {bcd[9:0], sign} to the staging registers of the current channel.
  - bcd[11:10] is always 0 because the clamp guarantees ≤ 399.
  - Increment the channel index: A → B → D. After D, go to COMMIT.
- **COMMIT (1 cycle):**
  - Copy all staging registers to the outputs in one edge.
  - Pulse `done`, drop `busy`, return to IDLE.
- **Output stability:** outputs never show a partial conversion. They hold their previous values until COMMIT.
- **Reset mid-conversion:** the conversion is aborted; no `done`; outputs go to their reset values.

## Timing
- `start` sampled high at edge t0 in IDLE → `busy` = 1 from t0 through edge t0+3·(WIDTH+2).
- Channel i (i = 0, 1, 2) occupies edges t0+1+i·(WIDTH+2) … t0+(i+1)·(WIDTH+2).
- COMMIT is at edge t0+3·WIDTH+7; this is 43 cycles for WIDTH=12.
  - Outputs and `done` = 1 become visible after that edge; `busy` = 0 at the same edge.
  - `done` clears at the next edge.
- Back-to-back operation: `start` held high continuously gives one conversion every 3·WIDTH+8 cycles. `start` in the `done` cycle is accepted because the FSM is already in IDLE.
- Input changes after t0 have no effect on the conversion in progress.

## Structure
- **Shared package `calc_pkg`:**
  - state enum {IDLE, LOAD, SHIFT, STORE, COMMIT};
  - channel enum {CH_A, CH_B, CH_D};
  - typedef `bcd10_t` (10-bit packed digits);
  - constant `BCD_DISPLAY_MAX` = 399.
- **Sub-module `bcd_dabble_step`:** combinational, one add-3-then-shift iteration on {12-bit BCD, WIDTH-bit magnitude}. It is instantiated once and used in SHIFT.

## Test plan
- a_bin=123, b_bin=-45, d_bin=78, start → after 43 cycles: A=10'h123, negativeA=0; B=10'h045, negativeB=1; D=10'h078; overflow=0; `done` high for exactly one cycle.
- d_bin=400, start → overflow=1, D=10'h000, negativeD=0. d_bin=-399 → D=10'h399, negativeD=1, overflow=0.
- a_bin=-2048, b_bin=1000 → A=10'h399 with negativeA=1; B=10'h399 with negativeB=0 (saturation). d_bin=-2048 → overflow=1.
- Pulse `start` again at cycle 10 of a conversion, and change the inputs mid-run → ignored; results reflect the t0 snapshot; `done` comes at t0+43 only.
- Assert `reset` at cycle 20 of a conversion → all outputs 0, busy=0, no `done`. A new `start` afterwards completes normally after 43 cycles.
- All zeros → A=B=D=10'h000, negatives 0, overflow 0. Then apply the previous values again → outputs update only at the COMMIT edge.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display path.
//   state_t         : sequencer states of the BCD result formatter
//   channel_t       : which operand is being converted (A, B, then D)
//   bcd10_t         : packed {hundreds[1:0], tens[3:0], ones[3:0]}
//   BCD_DISPLAY_MAX : largest magnitude a 10-bit BCD field can show
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    STORE,
    COMMIT
  } state_t;

  typedef enum logic [1:0] {
    CH_A,
    CH_B,
    CH_D
  } channel_t;

  typedef logic [9:0] bcd10_t;

  localparam int unsigned BCD_DISPLAY_MAX = 399;

endpackage

// File: rtl/bcd_dabble_step.sv
// One iteration of the shift-and-add-3 (double dabble) conversion.
// Every BCD nibble >= 5 gets 3 added, then {bcd, mag} shifts left by one.
//   i_bcd : 12-bit BCD accumulator (three nibbles)
//   i_mag : remaining binary magnitude bits, MSB shifted in next
//   o_bcd : accumulator after adjust and shift
//   o_mag : magnitude after shift (zero filled)
module bcd_dabble_step #(
  parameter int unsigned WIDTH = 12
) (
  input  logic [11:0]      i_bcd,
  input  logic [WIDTH-1:0] i_mag,
  output logic [11:0]      o_bcd,
  output logic [WIDTH-1:0] o_mag
);

  logic [11:0] w_adj;
  logic        w_unused_msb;

  always_comb begin
    w_adj = i_bcd;
    for (int unsigned n = 0; n < 3; n++) begin
      if (i_bcd[n*4 +: 4] >= 4'd5) begin
        w_adj[n*4 +: 4] = i_bcd[n*4 +: 4] + 4'd3;
      end
    end
  end

  // Top bit of the adjusted accumulator falls off the left end of the shift.
  assign w_unused_msb = w_adj[11];
  assign o_bcd        = {w_adj[10:0], i_mag[WIDTH-1]};
  assign o_mag        = {i_mag[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/bcd_result_formatter.sv
// Sequential binary-to-BCD stage feeding the seven-segment driver.
// On start (in IDLE) the three signed operands are snapshotted, converted one
// after another through a single shared dabble step, and all results are
// published together with a one-cycle done pulse.
//   clk, reset         : clock, synchronous active-high reset
//   start              : conversion request, honoured only in IDLE
//   a_bin, b_bin, d_bin: two's-complement operands / result
//   A, B, D            : sign-magnitude BCD {hund[1:0], tens, ones}
//   negativeA/B/D      : sign of the displayed value
//   overflow           : |d_bin| exceeded the displayable range
//   busy, done         : conversion in progress / results just updated
module bcd_result_formatter
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned MAX_MAG = BCD_DISPLAY_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_bin,
  input  logic [WIDTH-1:0] b_bin,
  input  logic [WIDTH-1:0] d_bin,
  output logic [9:0]       A,
  output logic [9:0]       B,
  output logic [9:0]       D,
  output logic             negativeA,
  output logic             negativeB,
  output logic             negativeD,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      CNT_W     = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_MAG_W = WIDTH'(MAX_MAG);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);

  state_t           r_state, w_next;
  channel_t         r_ch;
  logic [WIDTH-1:0] r_snap_a, r_snap_b, r_snap_d;
  logic [WIDTH-1:0] r_mag;
  logic             r_sign;
  logic [11:0]      r_bcd;
  logic [CNT_W-1:0] r_cnt;
  bcd10_t           r_stg_a, r_stg_b, r_stg_d;
  logic             r_stg_na, r_stg_nb, r_stg_nd, r_stg_ovf;
  bcd10_t           r_a, r_b, r_d;
  logic             r_na, r_nb, r_nd, r_ovf, r_busy, r_done;

  logic             w_capture, w_load, w_shift, w_store, w_commit;
  logic [WIDTH-1:0] w_src, w_abs;
  logic             w_sign, w_over;
  logic [11:0]      w_step_bcd;
  logic [WIDTH-1:0] w_step_mag;
  logic             w_unused_hi;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   if (r_cnt == LAST_CNT) w_next = STORE;
      STORE:   w_next = (r_ch == CH_D) ? COMMIT : LOAD;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ---------------- FSM: datapath strobes ----------------
  always_comb begin
    w_capture = 1'b0;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_store   = 1'b0;
    w_commit  = 1'b0;
    unique case (r_state)
      IDLE:    w_capture = start;
      LOAD:    w_load    = 1'b1;
      SHIFT:   w_shift   = 1'b1;
      STORE:   w_store   = 1'b1;
      COMMIT:  w_commit  = 1'b1;
      default: ;
    endcase
  end

  // ---------------- LOAD: sign / magnitude / clamp ----------------
  always_comb begin
    unique case (r_ch)
      CH_A:    w_src = r_snap_a;
      CH_B:    w_src = r_snap_b;
      default: w_src = r_snap_d;
    endcase
    w_sign = w_src[WIDTH-1];
    // Most-negative input wraps to itself, which reads as 2^(WIDTH-1) unsigned.
    w_abs  = w_sign ? (~w_src + {{(WIDTH-1){1'b0}}, 1'b1}) : w_src;
    w_over = (w_abs > MAX_MAG_W);
  end

  bcd_dabble_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_bcd(r_bcd),
    .i_mag(r_mag),
    .o_bcd(w_step_bcd),
    .o_mag(w_step_mag)
  );

  // Clamp keeps values <= 399, so the top two accumulator bits stay zero.
  assign w_unused_hi = |r_bcd[11:10];

  // ---------------- Datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch      <= CH_A;
      r_snap_a  <= '0;
      r_snap_b  <= '0;
      r_snap_d  <= '0;
      r_mag     <= '0;
      r_sign    <= 1'b0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_stg_a   <= '0;
      r_stg_b   <= '0;
      r_stg_d   <= '0;
      r_stg_na  <= 1'b0;
      r_stg_nb  <= 1'b0;
      r_stg_nd  <= 1'b0;
      r_stg_ovf <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_d       <= '0;
      r_na      <= 1'b0;
      r_nb      <= 1'b0;
      r_nd      <= 1'b0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_commit;

      if (w_capture) begin
        r_snap_a <= a_bin;
        r_snap_b <= b_bin;
        r_snap_d <= d_bin;
        r_ch     <= CH_A;
        r_busy   <= 1'b1;
      end

      if (w_load) begin
        r_bcd <= '0;
        r_cnt <= '0;
        if (r_ch == CH_D) begin
          // Out-of-range result shows as +000 with the overflow flag.
          r_stg_ovf <= w_over;
          r_mag     <= w_over ? '0 : w_abs;
          r_sign    <= w_over ? 1'b0 : w_sign;
        end else begin
          r_mag  <= w_over ? MAX_MAG_W : w_abs;
          r_sign <= w_sign;
        end
      end

      if (w_shift) begin
        r_bcd <= w_step_bcd;
        r_mag <= w_step_mag;
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_store) begin
        unique case (r_ch)
          CH_A: begin
            r_stg_a  <= r_bcd[9:0];
            r_stg_na <= r_sign;
            r_ch     <= CH_B;
          end
          CH_B: begin
            r_stg_b  <= r_bcd[9:0];
            r_stg_nb <= r_sign;
            r_ch     <= CH_D;
          end
          default: begin
            r_stg_d  <= r_bcd[9:0];
            r_stg_nd <= r_sign;
          end
        endcase
      end

      if (w_commit) begin
        r_a    <= r_stg_a;
        r_b    <= r_stg_b;
        r_d    <= r_stg_d;
        r_na   <= r_stg_na;
        r_nb   <= r_stg_nb;
        r_nd   <= r_stg_nd;
        r_ovf  <= r_stg_ovf;
        r_busy <= 1'b0;
      end
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign D         = r_d;
  assign negativeA = r_na;
  assign negativeB = r_nb;
  assign negativeD = r_nd;
  assign overflow  = r_ovf;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_bcd_result_formatter.sv
module tb_bcd_result_formatter;

  typedef struct packed {
    logic [9:0] a;
    logic       na;
    logic [9:0] b;
    logic       nb;
    logic [9:0] d;
    logic       nd;
    logic       ovf;
  } exp_t;

  typedef struct {
    int   a;
    int   b;
    int   d;
    exp_t e;
  } vec_t;

  localparam int LAT    = 43;
  localparam int PERIOD = 44;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [11:0] a_bin, b_bin, d_bin;
  logic [9:0]  A, B, D;
  logic        negativeA, negativeB, negativeD, overflow, busy, done;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t cur_out;

  always #5 clk = ~clk;

  bcd_result_formatter #(
    .WIDTH(12),
    .MAX_MAG(399)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .a_bin(a_bin), .b_bin(b_bin), .d_bin(d_bin),
    .A(A), .B(B), .D(D),
    .negativeA(negativeA), .negativeB(negativeB), .negativeD(negativeD),
    .overflow(overflow), .busy(busy), .done(done)
  );

  // ---------------- reference model ----------------
  function automatic logic [9:0] to_bcd(input int m);
    int h, t, o;
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    return 10'((h << 8) | (t << 4) | o);
  endfunction

  function automatic exp_t model(input int a, input int b, input int d);
    exp_t e;
    int   ma, mb, md;
    ma = (a < 0) ? -a : a;
    mb = (b < 0) ? -b : b;
    md = (d < 0) ? -d : d;
    if (ma > 399) ma = 399;
    if (mb > 399) mb = 399;
    e.a  = to_bcd(ma);
    e.na = (a < 0);
    e.b  = to_bcd(mb);
    e.nb = (b < 0);
    if (md > 399) begin
      e.ovf = 1'b1;
      e.d   = '0;
      e.nd  = 1'b0;
    end else begin
      e.ovf = 1'b0;
      e.d   = to_bcd(md);
      e.nd  = (d < 0);
    end
    return e;
  endfunction

  function automatic exp_t dut_out();
    return '{A, negativeA, B, negativeB, D, negativeD, overflow};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic drive(input int a, input int b, input int d);
    a_bin = 12'(a);
    b_bin = 12'(b);
    d_bin = 12'(d);
  endtask

  // Waits for done after start was sampled; outputs must hold cur_out and
  // busy must stay high until the done cycle. Optional mid-run start pulse
  // with junk inputs at cycle inj (0 = none).
  task automatic wait_done(input string nm, input int inj, output int cyc);
    logic hold_bad, busy_bad;
    hold_bad = 1'b0;
    busy_bad = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!done) begin
        if (dut_out() !== cur_out) hold_bad = 1'b1;
        if (busy !== 1'b1)         busy_bad = 1'b1;
      end
      if (inj != 0 && cyc == inj) begin
        start = 1'b1;
        drive(-7, 250, -300);
      end
      if (inj != 0 && cyc == inj + 1) start = 1'b0;
    end while (!done && cyc < 120);
    chk({nm, " hold"}, 64'(hold_bad), 64'd0);
    chk({nm, " busy_run"}, 64'(busy_bad), 64'd0);
    chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic run_vec(input string nm, input int a, input int b, input int d,
                         input exp_t e, input int inj);
    int cyc;
    drive(a, b, d);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " busy_t0"}, 64'(busy), 64'd1);
    wait_done(nm, inj, cyc);
    chk({nm, " latency"}, 64'(cyc), 64'(LAT));
    chk({nm, " outputs"}, 64'(dut_out()), 64'(e));
    cur_out = e;
    @(posedge clk); #1;
    chk({nm, " done_pulse"}, 64'(done), 64'd0);
  endtask

  vec_t tbl[6];

  initial begin
    int   cyc, ra, rb, rd;
    logic bad;
    logic signed [11:0] t12;
    exp_t e1, e2;

    tbl[0] = '{123, -45, 78,     exp_t'{10'h123, 1'b0, 10'h045, 1'b1, 10'h078, 1'b0, 1'b0}};
    tbl[1] = '{0, 0, 400,        exp_t'{10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1}};
    tbl[2] = '{0, 0, -399,       exp_t'{10'h000, 1'b0, 10'h000, 1'b0, 10'h399, 1'b1, 1'b0}};
    tbl[3] = '{-2048, 1000, -2048, exp_t'{10'h399, 1'b1, 10'h399, 1'b0, 10'h000, 1'b0, 1'b1}};
    tbl[4] = '{0, 0, 0,          exp_t'{10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0}};
    tbl[5] = '{123, -45, 78,     exp_t'{10'h123, 1'b0, 10'h045, 1'b1, 10'h078, 1'b0, 1'b0}};

    reset = 1'b1;
    start = 1'b0;
    drive(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    cur_out = '0;
    chk("reset outputs", 64'(dut_out()), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) run_vec($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].e, 0);

    // Restart request and input changes mid-run must be ignored.
    run_vec("midrun", 111, -222, 333, model(111, -222, 333), 10);
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done || busy) bad = 1'b1;
    end
    chk("midrun no_restart", 64'(bad), 64'd0);

    // Reset at cycle 20 aborts the conversion.
    drive(5, 6, 7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cur_out = '0;
    chk("abort outputs", 64'(dut_out()), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    bad = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done) bad = 1'b1;
    end
    chk("abort no_done", 64'(bad), 64'd0);
    run_vec("after_abort", -321, 99, -1, model(-321, 99, -1), 0);

    // start held high: back-to-back conversions, second snapshot taken at
    // the edge after the first done.
    e1 = model(-150, 207, 5);
    e2 = model(389, -1, -12);
    drive(-150, 207, 5);
    start = 1'b1;
    @(posedge clk); #1;
    drive(389, -1, -12);
    wait_done("b2b1", 0, cyc);
    chk("b2b1 latency", 64'(cyc), 64'(LAT));
    chk("b2b1 outputs", 64'(dut_out()), 64'(e1));
    cur_out = e1;
    wait_done("b2b2", 0, cyc);
    start = 1'b0;
    chk("b2b2 period", 64'(cyc), 64'(PERIOD));
    chk("b2b2 outputs", 64'(dut_out()), 64'(e2));
    cur_out = e2;
    @(posedge clk); #1;
    chk("b2b2 done_pulse", 64'(done), 64'd0);

    // Randomized operands against the model.
    for (int k = 0; k < 30; k++) begin
      if (k % 2 == 0) begin
        t12 = 12'($urandom); ra = t12;
        t12 = 12'($urandom); rb = t12;
        t12 = 12'($urandom); rd = t12;
      end else begin
        ra = int'($urandom_range(0, 1000)) - 500;
        rb = int'($urandom_range(0, 1000)) - 500;
        rd = int'($urandom_range(0, 1000)) - 500;
      end
      run_vec($sformatf("rnd%0d", k), ra, rb, rd, model(ra, rb, rd), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
